shift_register_ctl: RTL and testbench

Parametrised successor to the team's 4-bit right-shift register. It provides a WIDTH-bit register with parallel load, single-step shifting, and a multi-step shift command with busy/done handshake. Four shift modes are supported: logical right, logical left, rotate right and arithmetic right. The block sits in the datapath wherever serialisation, bit-field alignment or iterative shifting is needed, and it avoids the cost of a full barrel shifter.

---
 rtl/shift_register_ctl.sv | 131 +++++++++++++
 tb/tb_shift_register_ctl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_ctl.sv
// -----------------------------------------------------------------------------
// shift_register_ctl
//
// WIDTH-bit shift register with parallel load, single-step shifting and a
// multi-step shift command with busy/done handshake. It replaces the old
// fixed 4-bit right-shift register. Four shift modes are available: logical
// right, logical left, rotate right and arithmetic right. A multi-step
// command runs one step per clock, so no barrel shifter is needed.
//
// Ports:
//   clk       rising-edge clock
//   areset_n  asynchronous active-low reset
//   load      parallel load of data into q (highest priority, aborts RUN)
//   data      parallel load value
//   ena       single-step shift using the live mode (idle only)
//   start     begin a multi-step shift of 'amount' steps (idle only)
//   amount    number of steps for start (0 gives an immediate done pulse)
//   mode      00 LSR, 01 LSL, 10 ROR, 11 ASR
//   ser_in    fill bit for LSR/LSL, sampled on every shifting edge
//   q         register contents
//   ser_out   registered bit discarded by the most recent shift
//   busy      multi-step command in progress (state register)
//   done      one-cycle pulse when a multi-step command completes
// -----------------------------------------------------------------------------
module shift_register_ctl #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ena,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_LSL = 2'b01,
        MODE_ROR = 2'b10,
        MODE_ASR = 2'b11
    } mode_t;

    state_t           state;
    mode_t            mode_r;
    logic [AMT_W-1:0] cnt;

    // Shift results for the latched mode (RUN) and the live mode (ena).
    logic [WIDTH-1:0] run_q;
    logic             run_bit;
    logic [WIDTH-1:0] live_q;
    logic             live_bit;

    // One shift step; returns {discarded bit, new register value}.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] cur,
        input mode_t            m,
        input logic             fill
    );
        logic [WIDTH:0] res;
        res = '0;
        case (m)
            MODE_LSR: res = {cur[0],       fill,         cur[WIDTH-1:1]};
            MODE_LSL: res = {cur[WIDTH-1], cur[WIDTH-2:0], fill};
            MODE_ROR: res = {cur[0],       cur[0],       cur[WIDTH-1:1]};
            MODE_ASR: res = {cur[0],       cur[WIDTH-1], cur[WIDTH-1:1]};
            default:  res = {1'b0, cur};
        endcase
        return res;
    endfunction

    always_comb begin
        {run_bit, run_q}   = shift_step(q, mode_r, ser_in);
        {live_bit, live_q} = shift_step(q, mode_t'(mode), ser_in);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state   <= IDLE;
            mode_r  <= MODE_LSR;
            cnt     <= '0;
            q       <= '0;
            ser_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless set again below.
            done <= 1'b0;
            if (load) begin
                // Load aborts any command; an aborted command never pulses done.
                q     <= data;
                state <= IDLE;
                cnt   <= '0;
            end else if (state == RUN) begin
                q       <= run_q;
                ser_out <= run_bit;
                cnt     <= cnt - 1'b1;
                if (cnt == AMT_W'(1)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end else if (start) begin
                // Zero-length command completes at once without entering RUN.
                if (amount == '0) begin
                    done <= 1'b1;
                end else begin
                    cnt    <= amount;
                    mode_r <= mode_t'(mode);
                    state  <= RUN;
                end
            end else if (ena) begin
                q       <= live_q;
                ser_out <= live_bit;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_shift_register_ctl.sv
// -----------------------------------------------------------------------------
// tb_shift_register_ctl
//
// Self-checking bench for shift_register_ctl (WIDTH=8). Directed scenario
// tasks check fixed expected values; a randomized phase compares every cycle
// against a behavioural model built from arithmetic shifts and a step count.
// -----------------------------------------------------------------------------
module tb_shift_register_ctl;

    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;

    logic          clk;
    logic          areset_n;
    logic          load;
    logic [W-1:0]  data;
    logic          ena;
    logic          start;
    logic [AW-1:0] amount;
    logic [1:0]    mode;
    logic          ser_in;
    logic [W-1:0]  q;
    logic          ser_out;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [W-1:0] m_q;
    logic         m_so;
    logic         m_done;
    int           m_rem;
    logic [1:0]   m_mode;

    shift_register_ctl #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .load     (load),
        .data     (data),
        .ena      (ena),
        .start    (start),
        .amount   (amount),
        .mode     (mode),
        .ser_in   (ser_in),
        .q        (q),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_shift(input logic [W-1:0] v, input logic [1:0] md,
                               input logic fi, output logic [W-1:0] nv,
                               output logic so);
        int unsigned x;
        x = v;
        case (md)
            2'd0: begin so = v[0];   nv = W'((x >> 1) + (fi ? (1 << (W-1)) : 0)); end
            2'd1: begin so = v[W-1]; nv = W'((x * 2) % (1 << W) + (fi ? 1 : 0)); end
            2'd2: begin so = v[0];   nv = W'((x >> 1) + ((x % 2) << (W-1))); end
            default: begin so = v[0]; nv = W'($signed(v) >>> 1); end
        endcase
    endtask

    task automatic model_reset();
        m_q = '0; m_so = 1'b0; m_done = 1'b0; m_rem = 0; m_mode = 2'd0;
    endtask

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic step();
        logic [W-1:0] nq;
        logic         nso;
        @(posedge clk);
        if (!areset_n) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (load) begin
                m_q = data; m_rem = 0;
            end else if (m_rem > 0) begin
                model_shift(m_q, m_mode, ser_in, nq, nso);
                m_q = nq; m_so = nso; m_rem--;
                if (m_rem == 0) m_done = 1'b1;
            end else if (start) begin
                if (amount == 0) m_done = 1'b1;
                else begin m_rem = int'(amount); m_mode = mode; end
            end else if (ena) begin
                model_shift(m_q, mode, ser_in, nq, nso);
                m_q = nq; m_so = nso;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        load = 0; ena = 0; start = 0; data = '0; amount = '0; mode = 2'd0; ser_in = 0;
    endtask

    task automatic test_reset();
        areset_n = 0;
        for (int i = 0; i < 4; i++) begin
            load = 1'($urandom); ena = 1'($urandom); start = 1'($urandom);
            data = W'($urandom); amount = AW'($urandom); mode = 2'($urandom);
            ser_in = 1'($urandom);
            step();
        end
        checks++;
        if ({q, ser_out, busy, done} !== {8'h00, 3'b000}) begin
            failures++;
            $display("FAIL reset_hold q/so/busy/done=%h/%b/%b/%b exp 00/0/0/0", q, ser_out, busy, done);
        end
        idle_inputs();
        @(negedge clk);
        areset_n = 1;
        // Load something, then assert reset mid-cycle.
        load = 1; data = 8'h5A; ena = 1; mode = 2'd1; ser_in = 1;
        step();
        load = 0; ena = 0;
        step();
        checks++;
        if (q !== 8'h5A) begin
            failures++;
            $display("FAIL reset_preload q=%h exp 5a", q);
        end
        start = 1; amount = 4'd5;
        step();
        start = 0;
        #2 areset_n = 0;
        #1;
        model_reset();
        checks++;
        if ({q, ser_out, busy, done} !== {8'h00, 3'b000}) begin
            failures++;
            $display("FAIL reset_async q/so/busy/done=%h/%b/%b/%b exp 00/0/0/0", q, ser_out, busy, done);
        end
        step();
        @(negedge clk);
        areset_n = 1;
        idle_inputs();
    endtask

    task automatic test_ror_multi();
        logic [W-1:0] exp_q [3] = '{8'hD2, 8'h69, 8'hB4};
        int busy_cycles = 0;
        int done_count  = 0;
        load = 1; data = 8'hA5;
        step();
        load = 0; start = 1; mode = 2'd2; amount = 4'd3;
        step();
        start = 0; mode = 2'd0;
        checks++;
        if ({q, busy, done} !== {8'hA5, 2'b10}) begin
            failures++;
            $display("FAIL ror_start q/busy/done=%h/%b/%b exp a5/1/0", q, busy, done);
        end
        busy_cycles += int'(busy);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q !== exp_q[i]) begin
                failures++;
                $display("FAIL ror_step%0d q=%h exp %h", i, q, exp_q[i]);
            end
            busy_cycles += int'(busy);
            done_count  += int'(done);
        end
        step();
        done_count += int'(done);
        busy_cycles += int'(busy);
        checks++;
        if (busy_cycles !== 3 || done_count !== 1 || ser_out !== 1'b1) begin
            failures++;
            $display("FAIL ror_handshake busy_cycles=%0d done_pulses=%0d so=%b exp 3/1/1",
                     busy_cycles, done_count, ser_out);
        end
    endtask

    task automatic test_single_step();
        load = 1; data = 8'h90;
        step();
        load = 0; ena = 1; mode = 2'd3;
        step();
        checks++;
        if (q !== 8'hC8) begin
            failures++;
            $display("FAIL asr_1 q=%h exp c8", q);
        end
        step();
        checks++;
        if ({q, ser_out} !== {8'hE4, 1'b0}) begin
            failures++;
            $display("FAIL asr_2 q/so=%h/%b exp e4/0", q, ser_out);
        end
        ena = 0; load = 1; data = 8'h81;
        step();
        load = 0; ena = 1; mode = 2'd1; ser_in = 1;
        step();
        ena = 0; ser_in = 0;
        checks++;
        if ({q, ser_out, busy, done} !== {8'h03, 3'b100}) begin
            failures++;
            $display("FAIL lsl_1 q/so/busy/done=%h/%b/%b/%b exp 03/1/0/0", q, ser_out, busy, done);
        end
    endtask

    task automatic test_abort();
        load = 1; data = 8'hFF;
        step();
        load = 0; start = 1; mode = 2'd0; amount = 4'd5; ser_in = 0;
        step();
        start = 0;
        checks++;
        if ({q, busy, done} !== {8'hFF, 2'b10}) begin
            failures++;
            $display("FAIL abort_start q/busy/done=%h/%b/%b exp ff/1/0", q, busy, done);
        end
        step();
        checks++;
        if ({q, busy, done} !== {8'h7F, 2'b10}) begin
            failures++;
            $display("FAIL abort_busy1 q/busy/done=%h/%b/%b exp 7f/1/0", q, busy, done);
        end
        start = 1; ena = 1; mode = 2'd1; amount = 4'd1;
        step();
        start = 0; ena = 0; mode = 2'd0;
        checks++;
        if ({q, busy, done} !== {8'h3F, 2'b10}) begin
            failures++;
            $display("FAIL abort_ignore q/busy/done=%h/%b/%b exp 3f/1/0", q, busy, done);
        end
        load = 1; data = 8'h3C;
        step();
        load = 0;
        checks++;
        if ({q, busy, done} !== {8'h3C, 2'b00}) begin
            failures++;
            $display("FAIL abort_load q/busy/done=%h/%b/%b exp 3c/0/0", q, busy, done);
        end
        step();
        checks++;
        if ({q, busy, done} !== {8'h3C, 2'b00}) begin
            failures++;
            $display("FAIL abort_nodone q/busy/done=%h/%b/%b exp 3c/0/0", q, busy, done);
        end
    endtask

    task automatic test_amount_zero();
        load = 1; data = 8'h6B;
        step();
        load = 0; start = 1; amount = 4'd0; mode = 2'd2;
        step();
        start = 0;
        checks++;
        if ({q, busy, done} !== {8'h6B, 2'b01}) begin
            failures++;
            $display("FAIL amt0_done q/busy/done=%h/%b/%b exp 6b/0/1", q, busy, done);
        end
        step();
        checks++;
        if ({q, busy, done} !== {8'h6B, 2'b00}) begin
            failures++;
            $display("FAIL amt0_after q/busy/done=%h/%b/%b exp 6b/0/0", q, busy, done);
        end
    endtask

    task automatic test_lsr_saturate();
        logic [W-1:0] full = 8'hFF;
        load = 1; data = 8'hFF;
        step();
        load = 0; start = 1; mode = 2'd0; amount = 4'd9; ser_in = 0;
        step();
        start = 0;
        for (int i = 1; i <= 9; i++) begin
            step();
            checks++;
            if ({q, busy, done} !== {W'(full >> i), (i < 9), (i == 9)}) begin
                failures++;
                $display("FAIL lsr9_step%0d q/busy/done=%h/%b/%b exp %h/%b/%b",
                         i, q, busy, done, W'(full >> i), (i < 9), (i == 9));
            end
        end
        step();
        checks++;
        if ({q, busy, done} !== {8'h00, 2'b00}) begin
            failures++;
            $display("FAIL lsr9_after q/busy/done=%h/%b/%b exp 00/0/0", q, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        load = 1; data = 8'h01;
        step();
        load = 0; start = 1; mode = 2'd2; amount = 4'd2;
        step();
        start = 0;
        step();
        step();
        checks++;
        if ({q, busy, done} !== {8'h40, 2'b01}) begin
            failures++;
            $display("FAIL b2b_first q/busy/done=%h/%b/%b exp 40/0/1", q, busy, done);
        end
        start = 1; amount = 4'd1;
        step();
        start = 0;
        checks++;
        if ({q, busy, done} !== {8'h40, 2'b10}) begin
            failures++;
            $display("FAIL b2b_accept q/busy/done=%h/%b/%b exp 40/1/0", q, busy, done);
        end
        step();
        checks++;
        if ({q, busy, done} !== {8'h20, 2'b01}) begin
            failures++;
            $display("FAIL b2b_second q/busy/done=%h/%b/%b exp 20/0/1", q, busy, done);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 3000; i++) begin
            load   = ($urandom_range(15) == 0);
            start  = ($urandom_range(5) == 0);
            ena    = 1'($urandom);
            data   = W'($urandom);
            amount = AW'($urandom);
            mode   = 2'($urandom);
            ser_in = 1'($urandom);
            step();
            checks++;
            if ({q, ser_out, busy, done} !== {m_q, m_so, (m_rem > 0), m_done}) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cyc%0d q/so/busy/done=%h/%b/%b/%b exp %h/%b/%b/%b",
                             i, q, ser_out, busy, done, m_q, m_so, (m_rem > 0), m_done);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        areset_n = 0;
        test_reset();
        test_ror_multi();
        test_single_step();
        test_abort();
        test_amount_zero();
        test_lsr_saturate();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
